addr4u_share_ctrl: RTL and testbench
====================================

ADDR4U_SHARE_CTRL -- requirements
Module: addr4u_share_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2, meaning: max re-executions after a compare mismatch (range 0..7).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester operand valid (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4 each  unsigned operands.
REQ-007 SHALL have port rsp_valid  output  1  result valid.
REQ-008 SHALL have port rsp_ready  input  1  result consumed.
REQ-009 SHALL have ports rsp_sum  output  5  A+B, carry in bit 4; rsp_id  output  1  granted requester; rsp_err  output  1  unresolved mismatch.
REQ-010 SHALL have port flt_inj  input  5  test-only mask XORed onto adder output during EXEC1 only.
REQ-011 SHALL have ports busy  output  1  state != IDLE; err_cnt  output  8  saturating count of responses with rsp_err=1.

Function
REQ-012 SHALL share one 4-bit unsigned adder between two requesters; one operation in flight.
REQ-013 SHALL implement states IDLE, EXEC1, EXEC2, RESP.
REQ-014 IDLE: if any req_valid, grant one requester, assert its req_ready for that cycle only, latch its operands, clear retry_cnt, go EXEC1.
REQ-015 Arbitration: round-robin; pointer starts at requester 0, moves to the non-granted requester on each grant; sole valid requester wins regardless of pointer.
REQ-016 req_ready SHALL be 0 outside the IDLE grant cycle; req_valid without ready is held by the requester, not dropped.
REQ-017 EXEC1: register r1 = (a+b) ^ flt_inj; go EXEC2.
REQ-018 EXEC2: compute r2 = b+a (operands swapped on adder inputs); r1==r2 -> RESP with err=0; mismatch and retry_cnt<MAX_RETRY -> retry_cnt+1, EXEC1; mismatch and retry_cnt==MAX_RETRY -> RESP with err=1, rsp_sum=r2.
REQ-019 RESP: rsp_valid=1; rsp_sum, rsp_id, rsp_err stable until rsp_valid&&rsp_ready; then IDLE next cycle.
REQ-020 Latency: grant edge to rsp_valid = 3 cycles fault-free; +2 cycles per retry.
REQ-021 Width: 4+4 bit unsigned -> 5-bit sum; no truncation; 15+15 = 30 (5'b11110).
REQ-022 err_cnt SHALL increment at the RESP handshake when rsp_err=1 and saturate at 255.
REQ-023 Both requesters valid in the same cycle: only the pointer-selected one is granted; the other waits in IDLE.

Reset
REQ-024 During rst_n=0 all state clears immediately: state=IDLE, pointer=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_err=0, busy=0, err_cnt=0.
REQ-025 Reset mid-operation SHALL abort the operation with no response produced; the requester re-presents after reset.

Configuration
REQ-026 Macro ADDR4U_RECOMPUTE_EN defined: EXEC2 redundant compute and retry per REQ-018.
REQ-027 Macro absent: EXEC1 goes directly to RESP with rsp_sum=r1, rsp_err=0, err_cnt stays 0, latency 2 cycles, MAX_RETRY ignored.

Structure
REQ-028 Shared package addr4u_pkg SHALL hold the state enum, operand width (4), sum width (5) and err_cnt width (8).
REQ-029 The adder SHALL be sub-module addr4u_core (combinational, a[3:0], b[3:0] -> s[4:0]), instantiated once.

Verification
REQ-030 Req0 a=3,b=5, rsp_ready=1, inj=0 -> rsp_valid 3 cycles after grant, sum=8, id=0, err=0.
REQ-031 Both valid, req0 7+9, req1 15+15 -> req0 first (sum=16), then req1 (sum=30, id=1); pointer returns to 0.
REQ-032 flt_inj=5'b00001 for the first EXEC1 only, 2+2 -> one retry, sum=4, err=0, latency 5.
REQ-033 flt_inj=5'b10000 held, MAX_RETRY=2, 1+1 -> 3 EXEC1/EXEC2 passes, sum=2, err=1, err_cnt=1.
REQ-034 rsp_ready=0 for 4 cycles in RESP -> outputs stable, no new grant; rst_n low in EXEC2 -> all outputs 0 immediately.
REQ-035 Build without ADDR4U_RECOMPUTE_EN, 9+6 -> sum=15 after 2 cycles; flt_inj=1 -> sum=14, err=0.

Source files
------------

// File: rtl/addr4u_pkg.sv
// Shared types and widths for the shared 4-bit adder controller.
// Includes the state encoding, operand/sum/counter widths and a saturating increment.
package addr4u_pkg;

  localparam int OPW    = 4;
  localparam int SUMW   = 5;
  localparam int ERRW   = 8;
  localparam int RETRYW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    logic [ERRW-1:0] res;
    if (v == {ERRW{1'b1}}) begin
      res = v;
    end else begin
      res = v + ERRW'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/addr4u_core.sv
// Combinational 4+4 bit unsigned adder; the carry lands in bit 4 of the sum.
module addr4u_core
  import addr4u_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [SUMW-1:0] s
);

  assign s = SUMW'(a) + SUMW'(b);

endmodule

// File: rtl/addr4u_share_ctrl.sv
// Two-requester controller around one shared adder with round-robin grant.
// Define ADDR4U_RECOMPUTE_EN to add the swapped-operand recompute, compare and retry pass.
module addr4u_share_ctrl
  import addr4u_pkg::*;
#(
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req0_a,
  input  logic [OPW-1:0]   req0_b,
  input  logic [OPW-1:0]   req1_a,
  input  logic [OPW-1:0]   req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SUMW-1:0]  rsp_sum,
  output logic             rsp_id,
  output logic             rsp_err,
  input  logic [SUMW-1:0]  flt_inj,
  output logic             busy,
  output logic [ERRW-1:0]  err_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ptr;
  logic              r_id;
  logic [OPW-1:0]    r_a;
  logic [OPW-1:0]    r_b;
  logic              r_rsp_valid;
  logic [SUMW-1:0]   r_rsp_sum;
  logic              r_rsp_err;
  logic [ERRW-1:0]   r_err_cnt;
  logic              w_grant_id;
  logic [1:0]        w_req_ready;
  logic [OPW-1:0]    w_add_a;
  logic [OPW-1:0]    w_add_b;
  logic [SUMW-1:0]   w_sum;

`ifdef ADDR4U_RECOMPUTE_EN
  localparam logic [RETRYW-1:0] RETRY_LIM = RETRYW'(MAX_RETRY);
  logic [SUMW-1:0]   r_r1;
  logic [RETRYW-1:0] r_retry;
  logic              w_match;
  logic              w_retry;

  assign w_match = (w_sum == r_r1);
  assign w_retry = (!w_match) && (r_retry < RETRY_LIM);
`endif

  addr4u_core u_core (
    .a (w_add_a),
    .b (w_add_b),
    .s (w_sum)
  );

  // Round-robin pick: pointer only matters when both requesters are valid
  always_comb begin
    w_grant_id = 1'b0;
    case (req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = r_ptr;
      default: w_grant_id = 1'b0;
    endcase
  end

  // Next-state, grant strobe and adder input steering
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_add_a     = r_a;
    w_add_b     = r_b;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_state_nxt = ST_EXEC1;
          w_req_ready = w_grant_id ? 2'b10 : 2'b01;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC1: begin
`ifdef ADDR4U_RECOMPUTE_EN
        w_state_nxt = ST_EXEC2;
`else
        w_state_nxt = ST_RESP;
`endif
      end
      ST_EXEC2: begin
`ifdef ADDR4U_RECOMPUTE_EN
        // Swapped inputs so a stuck adder input bit shows up as a mismatch
        w_add_a = r_b;
        w_add_b = r_a;
        if (w_match) begin
          w_state_nxt = ST_RESP;
        end else if (w_retry) begin
          w_state_nxt = ST_EXEC1;
        end else begin
          w_state_nxt = ST_RESP;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, compare results, response and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_a         <= {OPW{1'b0}};
      r_b         <= {OPW{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= {SUMW{1'b0}};
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= {ERRW{1'b0}};
`ifdef ADDR4U_RECOMPUTE_EN
      r_r1        <= {SUMW{1'b0}};
      r_retry     <= {RETRYW{1'b0}};
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_id  <= w_grant_id;
            r_ptr <= ~w_grant_id;
            r_a   <= w_grant_id ? req1_a : req0_a;
            r_b   <= w_grant_id ? req1_b : req0_b;
`ifdef ADDR4U_RECOMPUTE_EN
            r_retry <= {RETRYW{1'b0}};
`endif
          end
        end
        ST_EXEC1: begin
`ifdef ADDR4U_RECOMPUTE_EN
          r_r1 <= w_sum ^ flt_inj;
`else
          r_rsp_sum   <= w_sum ^ flt_inj;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
`endif
        end
        ST_EXEC2: begin
`ifdef ADDR4U_RECOMPUTE_EN
          if (w_match) begin
            r_rsp_sum   <= w_sum;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else if (w_retry) begin
            r_retry <= r_retry + RETRYW'(1);
          end else begin
            r_rsp_sum   <= w_sum;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_err) begin
              r_err_cnt <= sat_inc(r_err_cnt);
            end
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Grant strobe is forced low while reset is held, even with requests pending
  assign req_ready = w_req_ready & {2{rst_n}};
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_id;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_addr4u_share_ctrl.sv
// Self-checking bench for addr4u_share_ctrl: directed scenarios then randomized traffic
// against a behavioural model; expectations follow ADDR4U_RECOMPUTE_EN when defined.
module tb_addr4u_share_ctrl;

  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_sum;
  logic       rsp_id;
  logic       rsp_err;
  logic [4:0] flt_inj;
  logic       busy;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ecnt  = 0;
  bit m_ptr   = 1'b0;

  always #5 clk = ~clk;

  addr4u_share_ctrl #(.MAX_RETRY(MR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .flt_inj   (flt_inj),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result from the rules: each failed compare costs one EXEC1/EXEC2 pass
  function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic [4:0] f,
                                input bit first_only, output int es, output int ee, output int el);
`ifdef ADDR4U_RECOMPUTE_EN
    int fails;
    int retries;
    if (f == 5'd0) fails = 0;
    else if (first_only) fails = 1;
    else fails = MR + 1;
    if (fails > MR) begin ee = 1; retries = MR; end
    else begin ee = 0; retries = fails; end
    es = int'(a) + int'(b);
    el = 3 + 2 * retries;
`else
    es = (int'(a) + int'(b)) ^ int'(f);
    ee = 0;
    el = 2;
`endif
  endfunction

  task automatic set_ops(input int rid, input logic [3:0] a, input logic [3:0] b);
    if (rid == 0) begin req0_a = a; req0_b = b; end
    else begin req1_a = a; req1_b = b; end
  endtask

  task automatic wait_grant(input int exp_id);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (req_ready !== 2'b00) got = 1'b1;
    end
    chk("grant_seen", got, 1);
    chk("grant_onehot", req_ready, (exp_id == 1) ? 2 : 1);
    m_ptr = (exp_id == 0);
  endtask

  task automatic complete(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [4:0] f, input bit first_only, input int stall,
                          input bit join_other);
    int es, ee, el, lat;
    bit seen;
    model(a, b, f, first_only, es, ee, el);
    @(negedge clk);
    req_valid[id] = 1'b0;
    if (join_other) req_valid[1-id] = 1'b1;
    flt_inj = f;
    chk("busy_exec", busy, 1);
    chk("ready_low_exec", req_ready, 0);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
        if (first_only && lat == 2) flt_inj = 5'd0;
      end
    end
    flt_inj = 5'd0;
    chk("rsp_seen", seen, 1);
    chk("latency", lat, el);
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_id", rsp_id, id);
    chk("rsp_err", rsp_err, ee);
    if (stall > 0) begin
      rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_sum", rsp_sum, es);
        chk("stall_id", rsp_id, id);
        chk("stall_err", rsp_err, ee);
        chk("stall_no_grant", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    if (ee != 0 && m_ecnt < 255) m_ecnt++;
    chk("rsp_drop", rsp_valid, 0);
    chk("busy_idle", busy, 0);
    chk("err_cnt", err_cnt, m_ecnt);
  endtask

  initial begin
    int pat, w, lo, stall;
    logic [3:0] a0, b0, a1, b1;
    logic [4:0] f0, f1;

    req_valid = 2'b01;
    rsp_ready = 1'b1;
    flt_inj   = 5'd0;
    req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;

    // Reset state, with a request pending to show the grant strobe stays low
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    // Both valid: requester 0 first (7+9), then requester 1 (15+15)
    set_ops(0, 4'd7, 4'd9);
    set_ops(1, 4'd15, 4'd15);
    req_valid = 2'b11;
    wait_grant(0);
    complete(0, 4'd7, 4'd9, 5'd0, 1'b0, 0, 1'b0);
    wait_grant(1);
    complete(1, 4'd15, 4'd15, 5'd0, 1'b0, 0, 1'b0);

    // Pointer back at 0: requester 0 with 3+5 wins a tie again
    set_ops(0, 4'd3, 4'd5);
    set_ops(1, 4'd0, 4'd0);
    req_valid = 2'b11;
    wait_grant(0);
    complete(0, 4'd3, 4'd5, 5'd0, 1'b0, 0, 1'b0);
    wait_grant(1);
    complete(1, 4'd0, 4'd0, 5'd0, 1'b0, 0, 1'b0);

    // Fault on the first EXEC1 only
    set_ops(0, 4'd2, 4'd2);
    req_valid = 2'b01;
    wait_grant(0);
    complete(0, 4'd2, 4'd2, 5'b00001, 1'b1, 0, 1'b0);

    // Persistent fault on the carry bit
    set_ops(1, 4'd1, 4'd1);
    req_valid = 2'b10;
    wait_grant(1);
    complete(1, 4'd1, 4'd1, 5'b10000, 1'b0, 0, 1'b0);

    // 9+6 clean, then with a held low-bit fault
    set_ops(0, 4'd9, 4'd6);
    req_valid = 2'b01;
    wait_grant(0);
    complete(0, 4'd9, 4'd6, 5'd0, 1'b0, 0, 1'b0);
    req_valid = 2'b01;
    wait_grant(0);
    complete(0, 4'd9, 4'd6, 5'd1, 1'b0, 0, 1'b0);

    // Response back-pressure for 4 cycles while requester 1 is waiting
    set_ops(0, 4'd5, 4'd6);
    set_ops(1, 4'd4, 4'd4);
    req_valid = 2'b01;
    wait_grant(0);
    complete(0, 4'd5, 4'd6, 5'd0, 1'b0, 4, 1'b1);
    wait_grant(1);
    complete(1, 4'd4, 4'd4, 5'd0, 1'b0, 0, 1'b0);

    // Reset while in EXEC2 aborts the operation; both requesters then re-present
    set_ops(0, 4'd4, 4'd4);
    req_valid = 2'b01;
    wait_grant(0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #2;
    set_ops(1, 4'd8, 4'd1);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_sum", rsp_sum, 0);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_rsp_err", rsp_err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err_cnt", err_cnt, 0);
    @(negedge clk);
    chk("arst_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    m_ptr = 1'b0;
    m_ecnt = 0;
    wait_grant(0);
    complete(0, 4'd4, 4'd4, 5'd0, 1'b0, 0, 1'b0);
    wait_grant(1);
    complete(1, 4'd8, 4'd1, 5'd0, 1'b0, 0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      pat = int'($urandom_range(1, 3));
      a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
      f0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      f1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      stall = int'($urandom_range(0, 2));
      set_ops(0, a0, b0);
      set_ops(1, a1, b1);
      req_valid = 2'(pat);
      w = (pat == 3) ? int'(m_ptr) : ((pat == 2) ? 1 : 0);
      wait_grant(w);
      if (w == 0) complete(0, a0, b0, f0, 1'b0, stall, 1'b0);
      else complete(1, a1, b1, f1, 1'b0, stall, 1'b0);
      if (pat == 3) begin
        lo = 1 - w;
        wait_grant(lo);
        if (lo == 0) complete(0, a0, b0, f0, 1'b0, 0, 1'b0);
        else complete(1, a1, b1, f1, 1'b0, 0, 1'b0);
      end
    end

`ifdef ADDR4U_RECOMPUTE_EN
    // Drive err_cnt into saturation
    set_ops(0, 4'd1, 4'd1);
    for (int it = 0; it < 256; it++) begin
      req_valid = 2'b01;
      wait_grant(0);
      complete(0, 4'd1, 4'd1, 5'b10000, 1'b0, 0, 1'b0);
    end
    chk("err_cnt_sat", err_cnt, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
